// File: rtl/twiddle_rom_sequencer_if.sv
// ---------------------------------------------------------------------------
// twiddle_rom_sequencer_if
//
// Purpose:
//   Word stream from the twiddle ROM sequencer to the FFT butterfly. Each
//   word carries the ROM data plus its group/index tag and a last flag.
//   Flow control is valid/ready. A word transfers (fire) on the rising clock
//   edge where tw_valid and tw_ready are both high.
//
// Parameters:
//   DATA_W  width of a twiddle word (Q8.8 by default)
//   GRP_W   width of the group field (ROM address width minus 2)
//
// Signals:
//   tw_valid  source -> sink  tw_data/tw_group/tw_idx/tw_last are valid
//   tw_ready  sink -> source  sink accepts the current word
//   tw_data   source -> sink  twiddle word
//   tw_group  source -> sink  group the word belongs to
//   tw_idx    source -> sink  index of the word within its group (0..3)
//   tw_last   source -> sink  final word of the sequence
//
// Modports:
//   master  the sequencer (drives the word, samples ready)
//   slave   the butterfly (samples the word, drives ready)
// ---------------------------------------------------------------------------
interface twiddle_rom_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int GRP_W  = 3
);

  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] tw_data;
  logic [GRP_W-1:0]  tw_group;
  logic [1:0]        tw_idx;
  logic              tw_last;

  modport master (
    output tw_valid,
    output tw_data,
    output tw_group,
    output tw_idx,
    output tw_last,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  tw_data,
    input  tw_group,
    input  tw_idx,
    input  tw_last,
    output tw_ready
  );

endinterface : twiddle_rom_sequencer_if

// File: rtl/twiddle_rom_sequencer.sv
// ---------------------------------------------------------------------------
// twiddle_rom_sequencer
//
// Purpose:
//   Sequences reads of a registered twiddle ROM (1-cycle read latency) for
//   the FFT stage of the CWT pipeline. A start pulse in IDLE captures an
//   inclusive range of 4-entry twiddle groups. The block then walks the ROM
//   addresses {group, idx} of that range and streams every word to the
//   butterfly with valid/ready flow control. Each word is tagged with its
//   group, its index and a last flag.
//
// Parameters:
//   ADDR_W  ROM address width. The group field has ADDR_W-2 bits and the
//           index field has 2 bits.
//   DATA_W  ROM word width (Q8.8 twiddle).
//   GROUPS  number of populated groups. The legal group numbers are
//           0..GROUPS-1.
//
// Ports:
//   clk        in   single clock, all logic on the rising edge
//   rst        in   synchronous reset, active high
//   start      in   start pulse, accepted only in IDLE
//   grp_first  in   first group to stream, sampled on an accepted start
//   grp_last   in   last group to stream (inclusive), sampled on an
//                   accepted start
//   abort      in   (only with TWSEQ_ABORT_EN) ends a running sequence
//   busy       out  high while filling or streaming
//   done       out  one-cycle pulse when a sequence ends
//   cfg_err    out  valid with done. 1 = range rejected, nothing streamed.
//   rom_addr   out  ROM address (combinational)
//   rom_data   in   registered ROM output
//   tw         master modport of twiddle_rom_sequencer_if (word stream)
//
// Configuration:
//   TWSEQ_ABORT_EN  When defined, adds the abort input. abort in FILL or
//                   STREAM ends the sequence through DONE with cfg_err=0.
//                   abort takes priority over a simultaneous fire. When the
//                   macro is undefined, a sequence always runs to its last
//                   word or to rst.
// ---------------------------------------------------------------------------
module twiddle_rom_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int GROUPS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-3:0] grp_first,
  input  logic [ADDR_W-3:0] grp_last,
`ifdef TWSEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  twiddle_rom_sequencer_if.master tw
);

  localparam int GRP_W = ADDR_W - 2;

  // GROUPS can equal 2**GRP_W, so the range check needs one extra bit.
  localparam logic [GRP_W:0] GROUPS_LIM = (GRP_W + 1)'(GROUPS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q,   cur_d;    // address of the word being shown
  logic [GRP_W-1:0]  last_q,  last_d;   // captured grp_last
  logic              err_q,   err_d;    // range of the last start was rejected

  logic              range_bad;
  logic              abort_req;
  logic              streaming;
  logic              fire;
  logic              cur_is_last;
  logic [ADDR_W-1:0] cur_next;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  assign range_bad = (grp_first > grp_last) || ({1'b0, grp_last} >= GROUPS_LIM);

`ifdef TWSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign streaming   = (state_q == S_STREAM);
  assign fire        = streaming && tw.tw_ready;
  assign cur_is_last = (cur_q == {last_q, 2'b11});

  // A plain increment of {group, idx} wraps idx 3 -> 0 and carries into the
  // group field.
  assign cur_next = cur_q + ADDR_W'(1);

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy    = (state_q == S_FILL) || streaming;
  assign done    = (state_q == S_DONE);
  assign cfg_err = err_q;

  // The ROM word lines up with cur_q because rom_addr always ran one cycle
  // ahead of cur_q. So the data can pass straight through.
  assign tw.tw_valid = streaming;
  assign tw.tw_data  = rom_data;
  assign tw.tw_group = cur_q[ADDR_W-1:2];
  assign tw.tw_idx   = cur_q[1:0];
  assign tw.tw_last  = streaming && cur_is_last;

  // -------------------------------------------------------------------------
  // Next-state and ROM address
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first. No path through
    // the case can leave one unassigned, so no latch is inferred.
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    err_d    = err_q;
    rom_addr = cur_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            cur_d   = {grp_first, 2'b00};
            last_d  = grp_last;
            state_d = S_FILL;
          end
        end
      end

      // rom_addr = cur_q here, so the first word is on rom_data in STREAM.
      S_FILL: begin
        state_d = abort_req ? S_DONE : S_STREAM;
      end

      // On a fire, present the next address now. The ROM output then matches
      // the shown word on the following cycle. When the word stalls, the
      // address and the data both hold.
      S_STREAM: begin
        if (fire) begin
          cur_d    = cur_next;
          rom_addr = cur_next;
          if (cur_is_last) begin
            state_d = S_DONE;
          end
        end
        if (abort_req) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all state. Every register then
    // updates from pre-edge values, whatever order the simulator runs the
    // processes in.
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule : twiddle_rom_sequencer

// File: tb/tb_twiddle_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tb_twiddle_rom_sequencer
//
// Self-checking bench for twiddle_rom_sequencer. A registered ROM model
// feeds the DUT. The expected word stream for a group range comes from the
// ROM contents and the range rules. Each test task drives one scenario and
// compares its own observations.
// Build with +define+TWSEQ_ABORT_EN to include the abort scenario.
// ---------------------------------------------------------------------------
module tb_twiddle_rom_sequencer;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int GROUPS = 7;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        grp;
    logic [1:0]        idx;
    logic              last;
    logic [ADDR_W-1:0] addr_after;   // rom_addr seen in the fire cycle
  } word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        grp_first;
  logic [2:0]        grp_last;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
`ifdef TWSEQ_ABORT_EN
  logic              abort;
  int                run_abort_at;
`endif

  twiddle_rom_sequencer_if #(.DATA_W(DATA_W), .GRP_W(ADDR_W-2)) tw_if ();

  twiddle_rom_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .GROUPS (GROUPS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .grp_first (grp_first),
    .grp_last  (grp_last),
`ifdef TWSEQ_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tw        (tw_if.master)
  );

  always #5 clk = ~clk;

  // Registered ROM: one cycle of read latency.
  logic [DATA_W-1:0] rom_mem [32];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int checks   = 0;
  int failures = 0;

  // Expected stream and the observations from the last drive_run.
  word_t exp_q[$];
  word_t run_obs[$];
  int    run_fill_addr, run_first_valid, run_done_cycle, run_done_pulses;
  int    run_stall_viol;
  logic  run_err_at_done, run_busy_c1, run_cfg_err_c1, run_busy_at_done;
  logic  run_valid_at_done;

  // Reference: groups first..last in order, indices 0..3 in each group.
  // The data is the ROM word at that address. last marks (last, 3).
  function automatic void build_expected(input int first, input int last);
    word_t w;
    exp_q.delete();
    for (int g = first; g <= last; g++) begin
      for (int i = 0; i < 4; i++) begin
        w.data       = rom_mem[g*4 + i];
        w.grp        = 3'(g);
        w.idx        = 2'(i);
        w.last       = (g == last) && (i == 3);
        w.addr_after = ADDR_W'((g*4 + i + 1) % 32);
        exp_q.push_back(w);
      end
    end
  endfunction

  // Number of positions where the observed stream differs from the expected
  // stream, plus any missing or extra words.
  function automatic int word_errors(input bit with_addr);
    int n = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= run_obs.size()) n++;
      else if (run_obs[k].data !== exp_q[k].data || run_obs[k].grp !== exp_q[k].grp ||
               run_obs[k].idx !== exp_q[k].idx || run_obs[k].last !== exp_q[k].last ||
               (with_addr && run_obs[k].addr_after !== exp_q[k].addr_after)) n++;
    end
    if (run_obs.size() > exp_q.size()) n += run_obs.size() - exp_q.size();
    return n;
  endfunction

  // Runs one sequence. Call at posedge+1 with the DUT idle. Cycle 0 drives
  // start. Inputs change at posedge+1 and outputs are sampled on the
  // negedge. ready_mode: 0 = always ready, 1 = ready on even cycles,
  // 2 = random. restart_at >= 0 pulses start again with a different range.
  task automatic drive_run(input int first, input int last, input int ready_mode,
                           input int restart_at);
    word_t cur, prev;
    bit    prev_stalled = 0;
    prev = '0;
    run_obs.delete();
    run_fill_addr = -1; run_first_valid = -1; run_done_cycle = -1;
    run_done_pulses = 0; run_stall_viol = 0;
    run_err_at_done = 1'bx; run_busy_c1 = 1'bx; run_cfg_err_c1 = 1'bx;
    run_busy_at_done = 1'bx; run_valid_at_done = 1'bx;
    for (int c = 0; c < 300; c++) begin
      start = (c == 0) || (c == restart_at);
      if (c == 0) begin
        grp_first = 3'(first);
        grp_last  = 3'(last);
      end else if (c == restart_at) begin
        grp_first = 3'd0;
        grp_last  = 3'd6;
      end else begin
        grp_first = 3'($urandom);
        grp_last  = 3'($urandom);
      end
      case (ready_mode)
        0:       tw_if.tw_ready = 1'b1;
        1:       tw_if.tw_ready = (c % 2 == 0);
        default: tw_if.tw_ready = 1'($urandom_range(0, 1));
      endcase
`ifdef TWSEQ_ABORT_EN
      abort = (c == run_abort_at);
`endif
      @(negedge clk);
      if (c == 1) begin
        run_busy_c1    = busy;
        run_cfg_err_c1 = cfg_err;
        run_fill_addr  = int'(rom_addr);
      end
      if (tw_if.tw_valid === 1'b1) begin
        if (run_first_valid < 0) run_first_valid = c;
        cur.data = tw_if.tw_data;  cur.grp = tw_if.tw_group;
        cur.idx  = tw_if.tw_idx;   cur.last = tw_if.tw_last;
        cur.addr_after = rom_addr;
        if (prev_stalled && (cur.data !== prev.data || cur.grp !== prev.grp ||
                             cur.idx !== prev.idx || cur.last !== prev.last))
          run_stall_viol++;
        if (tw_if.tw_ready) run_obs.push_back(cur);
        prev = cur;
        prev_stalled = !tw_if.tw_ready;
      end else begin
        prev_stalled = 0;
      end
      if (done === 1'b1) begin
        run_done_pulses++;
        if (run_done_cycle < 0) begin
          run_done_cycle    = c;
          run_err_at_done   = cfg_err;
          run_busy_at_done  = busy;
          run_valid_at_done = tw_if.tw_valid;
        end
      end
      @(posedge clk); #1;
      if (run_done_cycle >= 0 && c >= run_done_cycle + 3) break;
    end
    start = 1'b0;
`ifdef TWSEQ_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tw_if.tw_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    checks++; if (tw_if.tw_valid !== 1'b0) begin failures++; $display("FAIL reset_tw_valid got=%b want=0", tw_if.tw_valid); end
    checks++; if (tw_if.tw_last !== 1'b0) begin failures++; $display("FAIL reset_tw_last got=%b want=0", tw_if.tw_last); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One group at full rate: addresses 8..11, last on the 4th word.
  task automatic test_single_group();
    build_expected(2, 2);
    drive_run(2, 2, 0, -1);
    checks++; if (run_obs.size() !== 4) begin failures++; $display("FAIL t1_count got=%0d want=4", run_obs.size()); end
    checks++; if (word_errors(1) !== 0) begin failures++; $display("FAIL t1_words bad=%0d want=0", word_errors(1)); end
    checks++; if (run_fill_addr !== 8) begin failures++; $display("FAIL t1_fill_addr got=%0d want=8", run_fill_addr); end
    checks++; if (run_first_valid !== 2) begin failures++; $display("FAIL t1_latency got=%0d want=2", run_first_valid); end
    checks++; if (run_done_cycle !== 6) begin failures++; $display("FAIL t1_done_cycle got=%0d want=6", run_done_cycle); end
    checks++; if (run_done_pulses !== 1) begin failures++; $display("FAIL t1_done_pulses got=%0d want=1", run_done_pulses); end
    checks++; if (run_err_at_done !== 1'b0) begin failures++; $display("FAIL t1_cfg_err got=%b want=0", run_err_at_done); end
    checks++; if (run_busy_c1 !== 1'b1) begin failures++; $display("FAIL t1_busy_fill got=%b want=1", run_busy_c1); end
    checks++; if (run_busy_at_done !== 1'b0) begin failures++; $display("FAIL t1_busy_done got=%b want=0", run_busy_at_done); end
  endtask

  // Two groups with ready toggling: no drop or duplicate, stable under stall.
  task automatic test_stall();
    build_expected(4, 5);
    drive_run(4, 5, 1, -1);
    checks++; if (run_obs.size() !== 8) begin failures++; $display("FAIL t2_count got=%0d want=8", run_obs.size()); end
    checks++; if (word_errors(0) !== 0) begin failures++; $display("FAIL t2_words bad=%0d want=0", word_errors(0)); end
    checks++; if (run_stall_viol !== 0) begin failures++; $display("FAIL t2_stall_stable changes=%0d want=0", run_stall_viol); end
    checks++; if (run_done_pulses !== 1) begin failures++; $display("FAIL t2_done_pulses got=%0d want=1", run_done_pulses); end
  endtask

  // Random legal ranges with random back-pressure.
  task automatic test_random_ranges();
    for (int n = 0; n < 8; n++) begin
      int f, l;
      f = $urandom_range(0, GROUPS-1);
      l = $urandom_range(f, GROUPS-1);
      build_expected(f, l);
      drive_run(f, l, 2, -1);
      checks++; if (word_errors(0) !== 0) begin failures++; $display("FAIL rand_words first=%0d last=%0d bad=%0d want=0", f, l, word_errors(0)); end
      checks++; if (run_stall_viol !== 0) begin failures++; $display("FAIL rand_stall first=%0d last=%0d changes=%0d want=0", f, l, run_stall_viol); end
      checks++; if (run_done_pulses !== 1 || run_err_at_done !== 1'b0) begin failures++; $display("FAIL rand_done first=%0d last=%0d pulses=%0d err=%b want 1/0", f, l, run_done_pulses, run_err_at_done); end
    end
  endtask

  // Rejected ranges: nothing streamed, done with cfg_err within 2 cycles.
  task automatic test_cfg_err();
    int bad_first [3] = '{3, 0, 6};
    int bad_last  [3] = '{1, 7, 2};
    for (int n = 0; n < 3; n++) begin
      drive_run(bad_first[n], bad_last[n], 2, -1);
      checks++; if (run_first_valid !== -1) begin failures++; $display("FAIL t3_no_valid range=%0d..%0d valid_at=%0d want=none", bad_first[n], bad_last[n], run_first_valid); end
      checks++; if (run_done_cycle < 1 || run_done_cycle > 2) begin failures++; $display("FAIL t3_done_cycle range=%0d..%0d got=%0d want=1..2", bad_first[n], bad_last[n], run_done_cycle); end
      checks++; if (run_err_at_done !== 1'b1) begin failures++; $display("FAIL t3_cfg_err range=%0d..%0d got=%b want=1", bad_first[n], bad_last[n], run_err_at_done); end
      checks++; if (run_done_pulses !== 1) begin failures++; $display("FAIL t3_done_pulses got=%0d want=1", run_done_pulses); end
    end
  endtask

  // A start during STREAM is ignored, and cfg_err clears on the new run.
  task automatic test_start_ignored();
    build_expected(1, 3);
    drive_run(1, 3, 0, 4);
    checks++; if (run_cfg_err_c1 !== 1'b0) begin failures++; $display("FAIL t4_cfg_err_clear got=%b want=0", run_cfg_err_c1); end
    checks++; if (word_errors(0) !== 0) begin failures++; $display("FAIL t4_words bad=%0d want=0", word_errors(0)); end
    checks++; if (run_done_pulses !== 1) begin failures++; $display("FAIL t4_done_pulses got=%0d want=1", run_done_pulses); end
    checks++; if (run_done_cycle !== 14) begin failures++; $display("FAIL t4_done_cycle got=%0d want=14", run_done_cycle); end
  endtask

  // rst while grp 1 idx 2 is shown: back to reset values, no done pulse.
  task automatic test_reset_mid();
    bit found = 0;
    bit done_seen = 0;
    grp_first = 3'd1; grp_last = 3'd2; tw_if.tw_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (tw_if.tw_valid === 1'b1 && tw_if.tw_group === 3'd1 && tw_if.tw_idx === 2'd2) found = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!found) begin failures++; $display("FAIL t5_reach_g1i2 got=not_seen want=seen"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b want=0", busy); end
    checks++; if (tw_if.tw_valid !== 1'b0) begin failures++; $display("FAIL t5_tw_valid got=%b want=0", tw_if.tw_valid); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL t5_rom_addr got=%0d want=0", rom_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen = 1;
      @(posedge clk); #1;
    end
    checks++; if (done_seen) begin failures++; $display("FAIL t5_no_done got=pulse want=none"); end
  endtask

`ifdef TWSEQ_ABORT_EN
  // abort together with a fire on the third word of range 0..6.
  task automatic test_abort();
    build_expected(0, 6);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    run_abort_at = 4;
    drive_run(0, 6, 0, -1);
    run_abort_at = -1;
    checks++; if (word_errors(0) !== 0) begin failures++; $display("FAIL t6_words bad=%0d want=0", word_errors(0)); end
    checks++; if (run_done_cycle !== 5) begin failures++; $display("FAIL t6_done_cycle got=%0d want=5", run_done_cycle); end
    checks++; if (run_valid_at_done !== 1'b0) begin failures++; $display("FAIL t6_valid_off got=%b want=0", run_valid_at_done); end
    checks++; if (run_err_at_done !== 1'b0) begin failures++; $display("FAIL t6_cfg_err got=%b want=0", run_err_at_done); end
  endtask
`endif

  // -------------------------------------------------------------------------
  initial begin
    for (int a = 0; a < 32; a++) rom_mem[a] = 16'($urandom);
    rom_mem[8]  = 16'h0100; rom_mem[9]  = 16'h00B5;
    rom_mem[10] = 16'h0000; rom_mem[11] = 16'hFF4A;
    rom_mem[20] = 16'h0100; rom_mem[21] = 16'h00FE;
    rom_mem[22] = 16'h00FB; rom_mem[23] = 16'h00F4;
    start = 1'b0; grp_first = '0; grp_last = '0;
`ifdef TWSEQ_ABORT_EN
    abort = 1'b0; run_abort_at = -1;
`endif
    test_reset();
    test_single_group();
    test_stall();
    test_random_ranges();
    test_cfg_err();
    test_start_ignored();
    test_reset_mid();
`ifdef TWSEQ_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_twiddle_rom_sequencer
